reciprocal_nr_refine: RTL and testbench
=======================================

// Module: reciprocal_nr_refine
// PURPOSE
//  Downstream stage of the combinational seed reciprocal: takes the Q6.10 operand x and its
//  seed y0 ~ 1/x and applies ITERS Newton-Raphson steps, y <- y*(2 - x*y).
//  One shared signed 16x16 multiplier, FSM-sequenced, valid/ready on both sides.
//  Refined Q6.10 reciprocal goes to the divider datapath.
// PARAMETERS
//  W      16  datapath width, signed two's complement
//  FRAC   10  fractional bits (Q6.10); 2.0 = 16'h0800
//  ITERS  2   NR iterations per transaction, legal 1..7
// PORTS
//  i_clk    in   1   clock, all state on rising edge
//  i_rst    in   1   synchronous reset, active-high
//  i_valid  in   1   x/y0 valid
//  o_ready  out  1   block can accept; transfer when i_valid && o_ready
//  i_x      in   W   operand x, Q6.10
//  i_y0     in   W   seed reciprocal of x, Q6.10
//  o_valid  out  1   result valid
//  i_ready  in   1   consumer accepts; transfer when o_valid && i_ready
//  o_data   out  W   refined reciprocal, Q6.10, range [0,16'h7FFF]
//  o_dz     out  1   divide-by-zero (x == 0), qualified by o_valid
//  o_sat    out  1   saturation/clamp occurred in this transaction, qualified by o_valid
// BEHAVIOUR
//  Reset values:
//   - o_valid=0, o_data=0, o_dz=0, o_sat=0.
//   - o_ready=0 while i_rst=1; FSM is in IDLE afterwards.
//  FSM states: IDLE, MUL1, MUL2, DONE. Iteration counter 3 bits.
//  IDLE:
//   - o_ready=1.
//   - On accept, register x and y0; clear the sat and dz flags.
//   - x==0 -> DONE with o_data=16'h7FFF, o_dz=1.
//   - x<0 or y0<0 -> DONE with o_data=0, o_sat=1.
//   - Otherwise -> MUL1 with cnt=0.
//  MUL1: p = sat16((x*y) >>> FRAC); t = sat16(17'sh0800 - p); -> MUL2.
//  MUL2:
//   - y = clamp((y*t) >>> FRAC, 0, 16'h7FFF).
//   - cnt == ITERS-1 -> DONE; otherwise cnt++ -> MUL1.
//  DONE:
//   - o_valid=1; o_data/o_dz/o_sat held stable until i_ready.
//   - On handshake -> IDLE, o_valid=0 next cycle.
//  o_ready=0 in every state except IDLE; no input accepted in the same cycle as an output handshake.
//  Arithmetic rules:
//   - Products are full 32-bit signed.
//   - >>> is arithmetic shift (floor), no rounding.
//   - sat16 clamps to [16'h8000,16'h7FFF].
//   - Any clamp in MUL1 or MUL2 sets sticky o_sat.
//  Latency (accept edge = cycle 0):
//   - Normal: o_valid first high in cycle 2*ITERS+1 (5 at default).
//   - x==0 or negative operand: o_valid high in cycle 1.
//   - Throughput is one transaction per 2*ITERS+2 cycles minimum.
//  Input ports are sampled only on the accept edge; changes elsewhere are ignored.
//  i_rst mid-transaction aborts it: no o_valid is produced, state is discarded, block returns to IDLE.
//  i_valid and i_rst high together: reset wins, nothing accepted.
// TESTING
//  1. x=16'h0400, y0=16'h0400, ITERS=2 -> o_data=16'h0400, o_dz=0, o_sat=0, o_valid in cycle 5.
//  2. x=16'h0800, y0=16'h0180 -> iter1 y=16'h01E0, iter2 y=16'h01FE; o_data=16'h01FE.
//  3. x=16'h0000, any y0 -> o_data=16'h7FFF, o_dz=1, o_valid in cycle 1.
//  4. x=16'h0004, y0=16'h7FFF -> y clamps every iteration; o_data=16'h7FFF, o_sat=1.
//  5. Backpressure: case 2 with i_ready=0 for 10 cycles:
//     o_valid, o_data and flags stable, o_ready=0; release -> IDLE next cycle.
//  6. Reset mid-op: pulse i_rst in cycle 2 of case 2 -> no o_valid; o_ready=1 after release;
//     rerun case 2 gives 16'h01FE.

Source files
------------

// File: rtl/reciprocal_nr_refine.sv
// Newton-Raphson refinement of a Q6.10 reciprocal seed: y <- y*(2 - x*y), ITERS times,
// sequenced over a single shared signed multiplier with valid/ready on both sides.
module reciprocal_nr_refine #(
  parameter int W     = 16,
  parameter int FRAC  = 10,
  parameter int ITERS = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_y0,
  output logic                o_valid,
  input  logic                i_ready,
  output logic        [W-1:0] o_data,
  output logic                o_dz,
  output logic                o_sat
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL1 = 2'd1;
  localparam logic [1:0] S_MUL2 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W-1:0]          MAXV  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]          MINV  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] TWO_L = (2*W)'(2**(FRAC+1));
  localparam logic [2:0]            LAST  = 3'(ITERS-1);

  // Returns {clamped_flag, value} saturated to the signed W-bit range.
  function automatic logic [W:0] sat_w(input logic signed [2*W-1:0] v);
    logic [W:0] hi;
    hi = v[2*W-1:W-1];
    if (hi == '0 || hi == '1) sat_w = {1'b0, v[W-1:0]};
    else if (v[2*W-1])        sat_w = {1'b1, MINV};
    else                      sat_w = {1'b1, MAXV};
  endfunction

  // Returns {clamped_flag, value} clamped to [0, MAXV].
  function automatic logic [W:0] clamp_pos(input logic signed [2*W-1:0] v);
    if (v[2*W-1])                clamp_pos = {1'b1, {W{1'b0}}};
    else if (v[2*W-2:W-1] != '0) clamp_pos = {1'b1, MAXV};
    else                         clamp_pos = {1'b0, v[W-1:0]};
  endfunction

  logic [1:0]          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, t_q, t_d;
  logic [W-1:0]        data_q, data_d;
  logic                dz_q, dz_d, sat_q, sat_d;

  logic signed [W-1:0]   mul_a;
  logic signed [2*W-1:0] prod, shifted, p_ext, diff;
  logic [W:0]            p_sat, t_sat, y_cl;

  // Shared multiplier: x*y in MUL1, y*t in MUL2.
  always_comb begin
    mul_a   = (state_q == S_MUL1) ? x_q : t_q;
    prod    = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{y_q[W-1]}}, y_q});
    shifted = prod >>> FRAC;
    p_sat   = sat_w(shifted);
    p_ext   = {{W{p_sat[W-1]}}, p_sat[W-1:0]};
    diff    = TWO_L - p_ext;
    t_sat   = sat_w(diff);
    y_cl    = clamp_pos(shifted);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    t_d     = t_q;
    data_d  = data_q;
    dz_d    = dz_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          x_d   = i_x;
          y_d   = i_y0;
          cnt_d = 3'd0;
          dz_d  = 1'b0;
          sat_d = 1'b0;
          if (i_x == '0) begin
            data_d  = MAXV;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else if (i_x[W-1] || i_y0[W-1]) begin
            data_d  = '0;
            sat_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_MUL1;
          end
        end
      end
      S_MUL1: begin
        t_d     = t_sat[W-1:0];
        sat_d   = sat_q | p_sat[W] | t_sat[W];
        state_d = S_MUL2;
      end
      S_MUL2: begin
        y_d   = y_cl[W-1:0];
        sat_d = sat_q | y_cl[W];
        if (cnt_q == LAST) begin
          data_d  = y_cl[W-1:0];
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = S_MUL1;
        end
      end
      default: begin
        if (i_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      data_q  <= '0;
      dz_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dz_q    <= dz_d;
      sat_q   <= sat_d;
    end
  end

  // Operand and iterate registers carry no reset; they are reloaded on every accept.
  always_ff @(posedge i_clk) begin
    x_q <= x_d;
    y_q <= y_d;
    t_q <= t_d;
  end

  assign o_ready = (state_q == S_IDLE) && !i_rst;
  assign o_valid = (state_q == S_DONE);
  assign o_data  = data_q;
  assign o_dz    = dz_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_reciprocal_nr_refine.sv
// Bench for reciprocal_nr_refine: vector table plus random model vectors through a scoreboard,
// and hand-written backpressure / reset sequences.
module tb_reciprocal_nr_refine;
  logic        clk = 1'b0;
  logic        rst, i_valid, i_ready;
  logic [15:0] i_x, i_y0, o_data;
  logic        o_ready, o_valid, o_dz, o_sat;

  reciprocal_nr_refine #(.W(16), .FRAC(10), .ITERS(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_y0(i_y0), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_dz(o_dz), .o_sat(o_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y0;
    logic [15:0] d;
    logic        dz;
    logic        sat;
    int          lat;
    int          acc;
  } vec_t;

  vec_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   seen   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference computed from the arithmetic definition with plain integers.
  function automatic vec_t model(input int x, input int y0);
    vec_t r;
    int y, p, t;
    r.x = 16'(x); r.y0 = 16'(y0); r.dz = 1'b0; r.sat = 1'b0; r.lat = 5; r.acc = 0;
    y = y0;
    for (int i = 0; i < 2; i++) begin
      p = (x * y) >>> 10;
      if (p > 32767) begin p = 32767; r.sat = 1'b1; end
      if (p < -32768) begin p = -32768; r.sat = 1'b1; end
      t = 2048 - p;
      if (t > 32767) begin t = 32767; r.sat = 1'b1; end
      if (t < -32768) begin t = -32768; r.sat = 1'b1; end
      y = (y * t) >>> 10;
      if (y > 32767) begin y = 32767; r.sat = 1'b1; end
      if (y < 0) begin y = 0; r.sat = 1'b1; end
    end
    r.d = 16'(y);
    return r;
  endfunction

  always @(negedge clk) begin
    if (o_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", {31'd0, o_valid}, 32'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", cyc - q[0].acc, q[0].lat);
        end
        if (i_ready) begin
          vec_t e;
          e = q.pop_front();
          seen = 1'b0;
          chk("data", {16'd0, o_data}, {16'd0, e.d});
          chk("dz", {31'd0, o_dz}, {31'd0, e.dz});
          chk("sat", {31'd0, o_sat}, {31'd0, e.sat});
        end
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 of the cycle after the accept edge.
  task automatic send(input vec_t v);
    int n = 0;
    while (!o_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("ready_before_send", {31'd0, o_ready}, 32'd1);
    i_x     = v.x;
    i_y0    = v.y0;
    v.acc   = cyc;
    q.push_back(v);
    i_valid = 1'b1;
    @(posedge clk); #2;
    i_valid = 1'b0;
    i_x     = 16'($urandom);
    i_y0    = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  vec_t tbl[10];
  vec_t c2;

  initial begin
    tbl[0] = '{16'h0400, 16'h0400, 16'h0400, 1'b0, 1'b0, 5, 0};
    tbl[1] = '{16'h0800, 16'h0180, 16'h01FE, 1'b0, 1'b0, 5, 0};
    tbl[2] = '{16'h0000, 16'h1234, 16'h7FFF, 1'b1, 1'b0, 1, 0};
    tbl[3] = '{16'h0004, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 5, 0};
    tbl[4] = '{16'hFC00, 16'h0400, 16'h0000, 1'b0, 1'b1, 1, 0};
    tbl[5] = '{16'h0400, 16'h8000, 16'h0000, 1'b0, 1'b1, 1, 0};
    tbl[6] = '{16'h0200, 16'h0700, 16'h07FF, 1'b0, 1'b0, 5, 0};
    tbl[7] = '{16'h0400, 16'h0000, 16'h0000, 1'b0, 1'b0, 5, 0};
    tbl[8] = '{16'h0C00, 16'h0100, 16'h0154, 1'b0, 1'b0, 5, 0};
    tbl[9] = '{16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 5, 0};
    c2 = tbl[1];

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_x = '0; i_y0 = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data", {16'd0, o_data}, 32'd0);
    chk("rst_flags", {30'd0, o_dz, o_sat}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #2;

    for (int i = 0; i < 10; i++) begin
      send(tbl[i]);
      drain();
    end

    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = model(int'($urandom_range(1, 32767)), int'($urandom_range(0, 32767)));
      send(v);
      drain();
    end

    // Backpressure: result and flags must hold while the consumer stalls.
    i_ready = 1'b0;
    send(c2);
    begin
      int n = 0;
      while (!o_valid && n < 50) begin
        @(posedge clk); #2;
        n++;
      end
    end
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_data", {16'd0, o_data}, 32'h01FE);
      chk("bp_flags", {30'd0, o_dz, o_sat}, 32'd0);
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
      @(posedge clk); #2;
    end
    i_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_release_valid", {31'd0, o_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, o_ready}, 32'd1);
    chk("bp_popped", q.size(), 0);

    // Reset in cycle 2 of a normal transaction aborts it.
    send(c2);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, o_ready}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    q.delete();
    seen = 1'b0;
    #1;
    chk("midrst_ready_after", {31'd0, o_ready}, 32'd1);
    chk("midrst_valid_after", {31'd0, o_valid}, 32'd0);
    repeat (12) @(posedge clk);
    #2;
    send(c2);
    drain();

    // Reset together with a valid input: nothing is accepted.
    rst = 1'b1; i_valid = 1'b1; i_x = 16'h0000; i_y0 = 16'h0400;
    #1;
    chk("rstvld_ready", {31'd0, o_ready}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; i_valid = 1'b0;
    #1;
    chk("rstvld_valid", {31'd0, o_valid}, 32'd0);
    chk("rstvld_idle", {31'd0, o_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
